// File: rtl/game_pkg.sv
// Shared game constants: colour codes, player FSM encoding
// and the four stored 16-entry colour sequences.
package game_pkg;

   localparam logic [1:0] GREEN  = 2'd0;
   localparam logic [1:0] RED    = 2'd1;
   localparam logic [1:0] YELLOW = 2'd2;
   localparam logic [1:0] BLUE   = 2'd3;

   localparam int SEQ_LEN = 16;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_GAP,
      S_DONE
   } state_e;

   // Entry i sits in bits [2i+1:2i].
   // Table 0 is 0,1,2,3 repeated.
   localparam logic [31:0] SEQ0 = 32'hE4E4_E4E4;
   localparam logic [31:0] SEQ1 = 32'h9C36_D8B1;
   localparam logic [31:0] SEQ2 = 32'h4B1E_72C9;
   localparam logic [31:0] SEQ3 = 32'hD2A5_6F18;

   function automatic logic [1:0] seq_at(
      input logic [1:0] sel,
      input logic [3:0] i
   );
      logic [31:0] t;
      case (sel)
         2'd0:    t = SEQ0;
         2'd1:    t = SEQ1;
         2'd2:    t = SEQ2;
         default: t = SEQ3;
      endcase
      seq_at = t[{i, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/seq_rom.sv
// Combinational sequence lookup (sel, idx) -> colour code.
// Ports: sel_i table select, idx_i position, colour_o code.
module seq_rom
   import game_pkg::*;
(
   input  logic [1:0] sel_i,
   input  logic [3:0] idx_i,
   output logic [1:0] colour_o
);

   assign colour_o = seq_at(sel_i, idx_i);

endmodule

// File: rtl/sequence_player.sv
// Plays round+1 colours of a stored sequence as timed flashes.
// Ports: clk, R (sync active-low), start, round, seq_sel in;
// leds, idx, busy, done out (all registered).
module sequence_player
   import game_pkg::*;
#(
   parameter int ON_TICKS  = 25_000_000,
   parameter int OFF_TICKS = 12_500_000,
   parameter int TW        = 25
) (
   input  logic       clk,
   input  logic       R,
   input  logic       start,
   input  logic [3:0] round,
   input  logic [1:0] seq_sel,
   output logic [3:0] leds,
   output logic [3:0] idx,
   output logic       busy,
   output logic       done
);

   localparam logic [TW-1:0] ON_LD  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LD = TW'(OFF_TICKS - 1);

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [3:0]    idx_q, idx_d;
   logic [3:0]    round_q, round_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    leds_q, leds_d;
   logic          busy_q, done_q;
   logic [1:0]    colour;

   // Look up the colour for the next state so the
   // registered LEDs line up with the state change.
   seq_rom u_rom (
      .sel_i    (sel_d),
      .idx_i    (idx_d),
      .colour_o (colour)
   );

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      idx_d   = idx_q;
      round_d = round_q;
      sel_d   = sel_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               round_d = round;
               sel_d   = seq_sel;
               idx_d   = '0;
               timer_d = ON_LD;
               state_d = S_ON;
            end
         end
         S_ON: begin
            if (timer_q == '0) begin
               timer_d = OFF_LD;
               state_d = S_GAP;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         S_GAP: begin
            if (timer_q == '0) begin
               // Compare before increment: idx never wraps.
               if (idx_q == round_q) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  timer_d = ON_LD;
                  state_d = S_ON;
               end
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      leds_d = (state_d == S_ON) ? (4'b0001 << colour) : 4'b0000;
   end

   always_ff @(posedge clk) begin
      if (!R) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         idx_q   <= '0;
         round_q <= '0;
         sel_q   <= '0;
         leds_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         idx_q   <= idx_d;
         round_q <= round_d;
         sel_q   <= sel_d;
         leds_q  <= leds_d;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign leds = leds_q;
   assign idx  = idx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_sequence_player.sv
// Directed bench for sequence_player with short flash timing:
// table vectors for round 0 plus hand sequences for corner cases.
module tb_sequence_player;

   localparam int ON  = 3;
   localparam int OFF = 2;
   localparam int PER = ON + OFF;

   logic       clk = 1'b0;
   logic       R;
   logic       start;
   logic [3:0] round;
   logic [1:0] seq_sel;
   logic [3:0] leds;
   logic [3:0] idx;
   logic       busy;
   logic       done;

   int errors = 0;
   int checks = 0;

   sequence_player #(
      .ON_TICKS  (ON),
      .OFF_TICKS (OFF),
      .TW        (2)
   ) dut (
      .clk     (clk),
      .R       (R),
      .start   (start),
      .round   (round),
      .seq_sel (seq_sel),
      .leds    (leds),
      .idx     (idx),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic [3:0] round;
      logic [3:0] leds;
      logic [3:0] idx;
      logic       busy;
      logic       done;
   } vec_t;

   vec_t tab [8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [3:0] el,
                          input logic [3:0] ei, input logic eb,
                          input logic ed);
      chk({nm, ".leds"}, 32'(leds), 32'(el));
      chk({nm, ".idx"},  32'(idx),  32'(ei));
      chk({nm, ".busy"}, 32'(busy), 32'(eb));
      chk({nm, ".done"}, 32'(done), 32'(ed));
   endtask

   // Expected outputs n cycles after start accepted (n>=1),
   // sequence 0 so item k shows colour k mod 4.
   task automatic play(input string nm, input int r, input bit hold,
                       input bit disturb);
      int last;
      int item;
      int ph;
      logic [3:0] el;
      last = (r + 1) * PER + 1;
      for (int n = 1; n <= last; n++) begin
         start = (n == 1) || hold;
         if (n == 1) begin
            round   = 4'(r);
            seq_sel = 2'd0;
         end
         if (disturb && n == 4) begin
            start   = 1'b1;
            round   = 4'd7;
            seq_sel = 2'd1;
         end
         tick();
         if (n < last) begin
            item = (n - 1) / PER;
            ph   = (n - 1) % PER;
            el   = (ph < ON) ? (4'b0001 << (item % 4)) : 4'b0000;
            chk_all($sformatf("%s.c%0d", nm, n), el, 4'(item),
                    1'b1, 1'b0);
         end else begin
            chk_all($sformatf("%s.c%0d", nm, n), 4'b0, 4'(r),
                    1'b1, 1'b1);
         end
      end
   endtask

   initial begin
      tab[0] = '{1'b1, 4'd0, 4'b0001, 4'd0, 1'b1, 1'b0};
      tab[1] = '{1'b0, 4'd0, 4'b0001, 4'd0, 1'b1, 1'b0};
      tab[2] = '{1'b0, 4'd0, 4'b0001, 4'd0, 1'b1, 1'b0};
      tab[3] = '{1'b0, 4'd0, 4'b0000, 4'd0, 1'b1, 1'b0};
      tab[4] = '{1'b0, 4'd0, 4'b0000, 4'd0, 1'b1, 1'b0};
      tab[5] = '{1'b0, 4'd0, 4'b0000, 4'd0, 1'b1, 1'b1};
      tab[6] = '{1'b0, 4'd0, 4'b0000, 4'd0, 1'b0, 1'b0};
      tab[7] = '{1'b0, 4'd0, 4'b0000, 4'd0, 1'b0, 1'b0};

      // Reset with start held high.
      R = 1'b0;
      start = 1'b1;
      round = 4'd3;
      seq_sel = 2'd0;
      tick();
      tick();
      chk_all("rst", 4'b0, 4'd0, 1'b0, 1'b0);
      R = 1'b1;
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_all($sformatf("rst_idle%0d", i), 4'b0, 4'd0, 1'b0, 1'b0);
      end

      // Round 0 from table.
      for (int i = 0; i < 8; i++) begin
         start = tab[i].start;
         round = tab[i].round;
         tick();
         chk_all($sformatf("tab%0d", i), tab[i].leds, tab[i].idx,
                 tab[i].busy, tab[i].done);
      end

      play("r3", 3, 1'b0, 1'b0);
      start = 1'b0;
      tick();
      chk_all("r3_post", 4'b0, 4'd3, 1'b0, 1'b0);

      play("ign", 1, 1'b0, 1'b1);
      start = 1'b0;
      tick();
      chk_all("ign_post", 4'b0, 4'd1, 1'b0, 1'b0);
      tick();

      // Max round with start held: re-trigger after the idle cycle.
      play("r15", 15, 1'b1, 1'b0);
      round = 4'd2;
      tick();
      chk_all("r15_idle", 4'b0, 4'd15, 1'b0, 1'b0);
      tick();
      chk_all("r15_retrig", 4'b0001, 4'd0, 1'b1, 1'b0);
      start = 1'b0;
      R = 1'b0;
      tick();
      R = 1'b1;
      tick();

      // Reset during the second flash of round 3.
      start = 1'b1;
      round = 4'd3;
      tick();
      start = 1'b0;
      for (int n = 2; n <= 6; n++) tick();
      chk_all("mid_pre", 4'b0010, 4'd1, 1'b1, 1'b0);
      R = 1'b0;
      tick();
      chk_all("mid_rst", 4'b0, 4'd0, 1'b0, 1'b0);
      R = 1'b1;
      begin
         int seen;
         seen = 0;
         for (int n = 0; n < 30; n++) begin
            tick();
            if (done || busy || leds != 4'b0) seen++;
         end
         chk("mid_no_done", 32'(seen), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
